// File: rtl/std_skid_buf_pkg.sv
// std_skid_buf_pkg: occupancy state encoding for the two-entry skid slice.
package std_skid_buf_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/std_dff.sv
// std_dff: unconditional, unreset payload flop; any hold/load muxing lives in the caller.
module std_dff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) q <= d;
endmodule

// File: rtl/std_skid_buf.sv
// std_skid_buf: registered valid/ready slice with main + skid entries, strict FIFO order.
// Optional synchronous discard of held beats via STD_SKID_BUF_FLUSH_EN.
module std_skid_buf
  import std_skid_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef STD_SKID_BUF_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  state_t state, state_n;
  logic push, pop, clr;
  logic [WIDTH-1:0] main_d, main_q, skid_d, skid_q;
`ifdef STD_SKID_BUF_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  assign push   = s_valid & s_ready;
  assign pop    = m_valid & m_ready;
  assign m_data = main_q;
  always_comb begin
    state_n = state;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state)
      EMPTY: if (push) begin
        state_n = BUSY;
        main_d  = s_data;
      end
      BUSY: if (push && !pop) begin
        state_n = FULL;
        skid_d  = s_data;
      end else if (push) begin
        main_d  = s_data;
      end else if (pop) begin
        state_n = EMPTY;
      end
      FULL: if (pop) begin
        state_n = BUSY;
        main_d  = skid_q;
      end
      default: state_n = EMPTY;
    endcase
    if (clr) state_n = EMPTY;
  end
  // handshake outputs are flopped from the next state so neither path is combinational
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= EMPTY;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
    end else begin
      state   <= state_n;
      s_ready <= state_n != FULL;
      m_valid <= state_n != EMPTY;
    end
  end
  std_dff #(.WIDTH(WIDTH)) u_main (.clk(clk), .d(main_d), .q(main_q));
  std_dff #(.WIDTH(WIDTH)) u_skid (.clk(clk), .d(skid_d), .q(skid_q));
endmodule
